ds_adc_decim: RTL and testbench
===============================

DS_ADC_DECIM -- requirements
Module: ds_adc_decim

Interface
REQ-001 Parameter N, default 8: output sample width in bits; it SHALL be even and at least 4.
REQ-002 Parameter LOG2R, default N/2: log2 of the decimation ratio R; the block SHALL require N == 2*LOG2R.
REQ-003 clk  input  1  single clock for all logic; the block SHALL use one clock only.
REQ-004 reset  input  1  the block SHALL treat reset as synchronous and active-high.
REQ-005 comp_in  input  1  asynchronous comparator output (analog input vs. RC-filtered feedback).
REQ-006 fb_out  output  1  registered feedback bit to the external RC integrator; the implementation SHALL place this flop in the IOB.
REQ-007 sample  output  N  decimated result, excess-2^(N-1) coding (mid-scale 2^(N-1)).
REQ-008 sample_valid  output  1  the block SHALL pulse this high for one clk when sample updates.
REQ-009 overload  output  1  the block SHALL assert this with sample_valid when that sample was saturated.

Function
REQ-010 comp_in SHALL pass through a 2-flop synchronizer; fb_out SHALL be registered from the second synchronizer stage (3 clk latency comp_in->fb_out).
REQ-011 The filter input bit SHALL be exactly the current fb_out value, so the filter sees the fed-back bitstream.
REQ-012 Filter SHALL be sinc2 (CIC, 2 integrators at clk rate, decimate by R, 2 combs at output rate); all accumulators SHALL be N+1 bits, wrapping modulo 2^(N+1).
REQ-013 Phase counter SHALL count 0..R-1 continuously; the decimation strobe SHALL occur at phase R-1, so the strobe period is R clk.
REQ-014 On a strobe, the comb stages SHALL update and the result SHALL be registered; sample and sample_valid SHALL appear 1 clk after the strobe.
REQ-015 Full-scale result R^2 = 2^N SHALL saturate to 2^N-1 with overload=1; otherwise overload SHALL be 0.
REQ-016 Ones density d SHALL map to sample = round-down(d*2^N) for settled constant density.
REQ-017 After reset, the first decimation strobe SHALL be suppressed (no sample_valid); valid output SHALL start on the second strobe, and results SHALL be settled from the third valid sample.
REQ-018 sample SHALL hold its value between sample_valid pulses.

Reset
REQ-019 reset SHALL clear the synchronizer flops, fb_out, the integrators, the comb delays, the phase counter and the warm-up flag to 0 on the next clk edge.
REQ-020 In reset, sample SHALL be 2^(N-1) and sample_valid and overload SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame: no sample_valid for the partial frame, and warm-up (REQ-017) SHALL restart.

Structure
REQ-022 A shared package SHALL hold the width helpers (accumulator width N+1, R = 2^LOG2R), the mid-scale constant and the saturation constant.
REQ-023 The decimator SHALL be a sub-module, ds_sinc2_decim (bit in, strobe, N-bit result, overload); the synchronizer and feedback flop SHALL stay in the top level.

Verification
REQ-024 N=8, comp_in held 1 -> fb_out=1 after 3 clk; settled sample=255 with overload=1 on every valid.
REQ-025 comp_in held 0 -> settled sample=0, overload=0.
REQ-026 Alternating 1/0 each clk -> settled sample=128, overload=0.
REQ-027 Repeating pattern 1,0,0,0 -> settled sample=64; repeating 1,1,1,0 -> settled sample=192.
REQ-028 Count cycles between sample_valid pulses -> exactly 16; first pulse 33 clk after reset deassertion (second strobe + 1).
REQ-029 Assert reset for 1 clk at phase 7 of a frame -> no sample_valid for that frame, sample=128, and the next pulse arrives 33 clk after reset release.

Source files
------------

// File: rtl/ds_adc_decim_pkg.sv
// Shared constants and helpers for the delta-sigma ADC front end and its
// sinc2 decimator.
package ds_adc_decim_pkg;

  localparam int unsigned N_DEFAULT = 8;

  // Warm-up tracker: the first decimation strobe after reset is discarded.
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } warm_state_e;

  // Accumulator width: one bit above the sample width so R^2 = 2^N fits.
  function automatic int unsigned acc_width(input int unsigned n);
    return n + 32'd1;
  endfunction

  function automatic int unsigned ratio(input int unsigned log2r);
    return 32'd1 << log2r;
  endfunction

  function automatic int unsigned mid_scale(input int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction

  function automatic int unsigned sat_value(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/ds_sinc2_decim.sv
// Second-order CIC decimator: two integrators at clk rate, two combs at the
// strobe rate, saturating N-bit result with an overload pulse.
module ds_sinc2_decim
  import ds_adc_decim_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_i,
  input  logic         strobe_i,
  input  logic         emit_i,
  output logic [N-1:0] result_o,
  output logic         overload_o
);

  localparam int unsigned AW  = acc_width(N);
  localparam logic [N-1:0] MID = N'(mid_scale(N));
  localparam logic [N-1:0] SAT = N'(sat_value(N));

  logic [AW-1:0] int1_q, int1_d;
  logic [AW-1:0] int2_q, int2_d;
  logic [AW-1:0] dly1_q, dly1_d;
  logic [AW-1:0] dly2_q, dly2_d;
  logic [AW-1:0] comb1_c, comb2_c;
  logic [N-1:0]  result_q, result_d;
  logic          overload_q, overload_d;

  // Integrators run every clk; combs and result only move on a strobe.
  always_comb begin
    int1_d     = int1_q + AW'(bit_i);
    int2_d     = int2_q + int1_q;
    comb1_c    = int2_q - dly1_q;
    comb2_c    = comb1_c - dly2_q;
    dly1_d     = dly1_q;
    dly2_d     = dly2_q;
    result_d   = result_q;
    overload_d = 1'b0;
    if (strobe_i) begin
      dly1_d = int2_q;
      dly2_d = comb1_c;
      if (emit_i) begin
        // Only full scale (2^N) sets the top bit once the filter has settled.
        if (comb2_c[N]) begin
          result_d   = SAT;
          overload_d = 1'b1;
        end else begin
          result_d = comb2_c[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int1_q     <= '0;
      int2_q     <= '0;
      dly1_q     <= '0;
      dly2_q     <= '0;
      result_q   <= MID;
      overload_q <= 1'b0;
    end else begin
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      dly1_q     <= dly1_d;
      dly2_q     <= dly2_d;
      result_q   <= result_d;
      overload_q <= overload_d;
    end
  end

  assign result_o   = result_q;
  assign overload_o = overload_q;

endmodule

// File: rtl/ds_adc_decim.sv
// Delta-sigma ADC digital front end: comparator synchronizer, registered
// feedback bit to the RC integrator, and sinc2 decimation to N-bit samples.
module ds_adc_decim
  import ds_adc_decim_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned LOG2R = N / 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         comp_in,
  output logic         fb_out,
  output logic [N-1:0] sample,
  output logic         sample_valid,
  output logic         overload
);

  localparam int unsigned R = ratio(LOG2R);
  localparam logic [LOG2R-1:0] PH_LAST = LOG2R'(R - 32'd1);

  if ((N % 2) != 0 || N < 4 || N != 2 * LOG2R) begin : g_bad_params
    $error("ds_adc_decim: N must be even, at least 4, and equal to 2*LOG2R");
  end

  logic             sync1_q, sync2_q;
  (* IOB = "TRUE" *) logic fb_q;
  logic [LOG2R-1:0] phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             strobe_c;
  logic             emit_c;
  warm_state_e      state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase counter wraps naturally at R; the strobe marks the last phase.
  always_comb begin
    phase_d  = phase_q + LOG2R'(1);
    strobe_c = (phase_q == PH_LAST);
    state_d  = state_q;
    emit_c   = 1'b0;
    valid_d  = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (strobe_c) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        emit_c  = strobe_c;
        valid_d = strobe_c;
      end
      default: state_d = ST_WARMUP;
    endcase
  end

  // comp_in is asynchronous; fb_q is the bit both the RC loop and filter see.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fb_q    <= 1'b0;
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= comp_in;
      sync2_q <= sync1_q;
      fb_q    <= sync2_q;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  ds_sinc2_decim #(
    .N (N)
  ) u_decim (
    .clk        (clk),
    .reset      (reset),
    .bit_i      (fb_q),
    .strobe_i   (strobe_c),
    .emit_i     (emit_c),
    .result_o   (sample),
    .overload_o (overload)
  );

  assign fb_out       = fb_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_ds_adc_decim.sv
// Bench for ds_adc_decim: periodic comparator patterns (fixed and random)
// checked against the ones-density transfer rule and the sample timing.
module tb_ds_adc_decim;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       comp_in = 1'b0;
  logic       fb_out;
  logic [7:0] sample;
  logic       sample_valid;
  logic       overload;

  int          errs = 0;
  int          checks = 0;
  int          rel_cyc;
  int          nval;
  int          skip;
  int          last_v;
  bit          first_seen;
  logic [15:0] pat;
  logic [31:0] exp_s;
  logic [31:0] exp_o;
  logic        comp_log [0:4095];

  ds_adc_decim #(
    .N     (8),
    .LOG2R (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overload     (overload)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d after reset)", tag, got, exp, rel_cyc);
    end
  endtask

  // Runs one cycle: rel_cyc+1 is the cycle being driven and observed.
  task automatic tick();
    rel_cyc++;
    comp_in = pat[rel_cyc % 16];
    comp_log[rel_cyc % 4096] = comp_in;
    if (rel_cyc >= 4)
      check("fb_out", 32'(fb_out), 32'(comp_log[(rel_cyc - 3) % 4096]));
    else
      check("fb_out_early", 32'(fb_out), 32'd0);
    if (sample_valid) begin
      if (!first_seen) begin
        check("first_valid_cycle", 32'(rel_cyc), 32'd33);
        first_seen = 1'b1;
      end else begin
        check("valid_period", 32'(rel_cyc - last_v), 32'd16);
      end
      last_v = rel_cyc;
      nval++;
      if (nval > skip) begin
        check("sample", 32'(sample), exp_s);
        check("overload", 32'(overload), exp_o);
      end
    end else if (!first_seen) begin
      check("warmup_sample", 32'(sample), 32'd128);
      check("warmup_overload", 32'(overload), 32'd0);
      if (rel_cyc == 33) check("first_valid_missing", 32'(sample_valid), 32'd1);
    end else if (nval > skip) begin
      check("hold", 32'(sample), exp_s);
    end
    @(posedge clk);
    #1;
  endtask

  // Expected settled output: ones density k/16 maps to floor(k/16 * 256).
  task automatic run_pat(input logic [15:0] p, input int skip_in, input int n_chk);
    int k;
    int budget;
    pat    = p;
    k      = $countones(p);
    exp_s  = (k == 16) ? 32'd255 : 32'(k * 16);
    exp_o  = (k == 16) ? 32'd1 : 32'd0;
    nval   = 0;
    skip   = skip_in;
    budget = (skip_in + n_chk + 3) * 16;
    for (int i = 0; i < budget && nval < skip_in + n_chk; i++) tick();
    check("valid_count", 32'(nval), 32'(skip_in + n_chk));
  endtask

  task automatic release_reset();
    check("rst_sample", 32'(sample), 32'd128);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overload", 32'(overload), 32'd0);
    check("rst_fb_out", 32'(fb_out), 32'd0);
    reset      = 1'b0;
    rel_cyc    = 0;
    first_seen = 1'b0;
    last_v     = 0;
  endtask

  initial begin
    pat   = '0;
    nval  = 0;
    skip  = 0;
    exp_s = 32'd128;
    exp_o = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Results are settled from the third valid sample after reset.
    run_pat(16'hFFFF, 2, 3);
    run_pat(16'h0000, 3, 2);
    run_pat(16'h5555, 3, 2);
    run_pat(16'h1111, 3, 2);
    run_pat(16'h7777, 3, 2);
    for (int r = 0; r < 6; r++) run_pat(16'($urandom), 3, 2);
    run_pat(16'hFFFF, 3, 2);

    // One-clk reset during phase 7 of a frame aborts it and restarts warm-up.
    while (((rel_cyc + 1) % 16) != 8) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    release_reset();
    run_pat(16'h0777, 2, 2);
    run_pat(16'($urandom), 3, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
